booth_mul_iter: RTL and testbench
=================================

Name: booth_mul_iter

Overview:
- Parametrised, iterative radix-4 Booth multiplier for the execute stage's M-extension path.
- Generates PP_PER_CYCLE Booth partial products per clock and accumulates them in a 2*(XLEN+2)-bit register.
- Returns the low or high XLEN bits according to op mode.
- Supports signed, unsigned and mixed-sign operands, 32-bit word mode, valid/ready handshakes and pipeline flush.

Parameters:
- XLEN, 64: operand/result width; must be even, >= 8.
- PP_PER_CYCLE, 1: partial products accumulated per CALC cycle; must divide NPP = (XLEN+2)/2. Legal values at 64: 1, 3, 11, 33.

Ports:
- clk, in, 1: clock, rising edge.
- rst_n, in, 1: asynchronous active-low reset.
- flush, in, 1: kills any in-flight operation.
- in_valid, in, 1: operation request.
- in_ready, out, 1: accepting request.
- src1, in, XLEN: multiplicand.
- src2, in, XLEN: multiplier.
- src1_signed, in, 1: treat src1 as signed.
- src2_signed, in, 1: treat src2 as signed.
- high, in, 1: select product bits [2*XLEN-1:XLEN].
- word, in, 1: 32-bit mode (mulw).
- out_valid, out, 1: result available.
- out_ready, in, 1: consumer accepts result.
- result, out, XLEN: product result.

Behaviour:
- Reset values: state=IDLE; in_ready=1, out_valid=0, result=0; internal accumulator, counter and operand registers =0.
- States:
  - IDLE: in_ready=1. On in_valid && !flush: latch operands and mode, clear accumulator, cnt=0, go to CALC.
  - CALC: in_ready=0. Each cycle, add PP_PER_CYCLE partial products and cnt += PP_PER_CYCLE. When cnt reaches NPP, go to DONE.
  - DONE: out_valid=1; result is held stable. On out_ready, go to IDLE. Back-to-back acceptance is not supported: in_ready returns to 1 the cycle after the handshake.
- Operand extension (XLEN+2 bits):
  - Top 2 bits = sign bit if the operand is signed, else 0.
  - In word mode, operands are first sign-extended from bit 31 regardless of the signed flags, and high is ignored.
- Booth step i, for i = 0..NPP-1:
  - Select triple {y[2i+1], y[2i], y[2i-1]}, with y[-1]=0.
  - 000/111 -> 0; 001/010 -> +X; 011 -> +2X; 100 -> -2X; 101/110 -> -X.
  - Negation is ~(X or 2X) plus 1, sign-extended to the full accumulator width and shifted left by 2i.
- Output selection:
  - high=0: acc[XLEN-1:0].
  - high=1: acc[2*XLEN-1:XLEN].
  - word=1: sign-extend acc[31:0] to XLEN.
- Latency: in handshake -> out_valid = NPP/PP_PER_CYCLE + 1 cycles (34 at defaults).
- flush: in any state, next state=IDLE and out_valid=0 next cycle. flush during an IDLE in_valid drops the request.
- Reset mid-operation: asynchronous return to reset values; no result is emitted.
- Simultaneous out_ready and flush in DONE: flush wins, and the result counts as not delivered.
- Zero operand: full latency is still taken; there is no early termination.

Decomposition:
- Shared defines (defines.v): XLEN default, Booth select encodings, FSM state encodings (IDLE/CALC/DONE).
- Sub-module booth_pp_gen #(W):
  - Takes a select triple and a W-bit extended multiplicand.
  - Produces a W+1-bit partial product with the +1 correction folded in.
  - One instance per PP_PER_CYCLE.

Test Plan:
1. Signed low: src1=3, src2=5, signed/signed -> result=15; out_valid exactly 34 cycles after the handshake.
2. Unsigned high: src1=src2=0xFFFF_FFFF_FFFF_FFFF, unsigned/unsigned, high=1 -> 0xFFFF_FFFF_FFFF_FFFE. Same operands signed/signed -> high 0x0, low 0x1.
3. Mixed sign (mulhsu): src1=-1 signed, src2=0xFFFF_FFFF_FFFF_FFFF unsigned, high=1 -> 0xFFFF_FFFF_FFFF_FFFF.
4. Word mode: src1=0x7FFF_FFFF, src2=2, word=1 -> 0xFFFF_FFFF_FFFF_FFFE; upper operand bits set to garbage do not change the result.
5. Backpressure/flush: hold out_ready=0 for 10 cycles -> result and out_valid stable. Flush at CALC cycle 10 -> out_valid never asserts, in_ready=1 next cycle, next op 7*6=42 correct.
6. Reset mid-CALC: drop rst_n at cycle 5 -> outputs go to reset values immediately; post-reset op -8*8 -> 0xFFFF_FFFF_FFFF_FFC0. Repeat tests 1-4 with PP_PER_CYCLE=3 and 11.

Source files
------------

// File: rtl/booth_mul_iter_pkg.sv
// Shared types and helpers for the iterative radix-4 Booth multiplier.
package booth_mul_iter_pkg;

  localparam int XLEN_DEFAULT = 64;
  localparam int WORD_BITS    = 32;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    PP_ZERO = 3'd0,
    PP_POS1 = 3'd1,
    PP_POS2 = 3'd2,
    PP_NEG1 = 3'd3,
    PP_NEG2 = 3'd4
  } pp_op_e;

  // Triple is {y[2i+1], y[2i], y[2i-1]}.
  function automatic pp_op_e booth_decode(input logic [2:0] sel);
    pp_op_e op;
    op = PP_ZERO;
    case (sel)
      3'b001, 3'b010: op = PP_POS1;
      3'b011:         op = PP_POS2;
      3'b100:         op = PP_NEG2;
      3'b101, 3'b110: op = PP_NEG1;
      default:        op = PP_ZERO;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/booth_mul_iter_pp_gen.sv
// One radix-4 Booth partial product: selects 0, +-X or +-2X of a W-bit
// signed multiplicand and returns it as a W+1-bit two's-complement value.
module booth_pp_gen
  import booth_mul_iter_pkg::*;
#(
  parameter int W = 66
) (
  input  logic [2:0] sel,
  input  logic [W-1:0] mcand,
  output logic [W:0] pp
);

  localparam logic [W:0] ONE = {{W{1'b0}}, 1'b1};

  logic [W:0] x1;
  logic [W:0] x2;

  assign x1 = {mcand[W-1], mcand};
  assign x2 = {mcand, 1'b0};

  always_comb begin
    pp = '0;
    case (booth_decode(sel))
      PP_POS1: pp = x1;
      PP_POS2: pp = x2;
      PP_NEG1: pp = ~x1 + ONE;
      PP_NEG2: pp = ~x2 + ONE;
      default: pp = '0;
    endcase
  end

endmodule

// File: rtl/booth_mul_iter.sv
// Iterative radix-4 Booth multiplier for the M-extension execute path.
//
//   state  | meaning
//   IDLE   | ready for a request; operands latched on in_valid && !flush
//   CALC   | PP_PER_CYCLE partial products accumulated per cycle
//   DONE   | result presented, held until out_ready
module booth_mul_iter
  import booth_mul_iter_pkg::*;
#(
  parameter int XLEN         = XLEN_DEFAULT,
  parameter int PP_PER_CYCLE = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  input  logic            src1_signed,
  input  logic            src2_signed,
  input  logic            high,
  input  logic            word,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result
);

  localparam int W   = XLEN + 2;
  localparam int NPP = W / 2;
  localparam int AW  = 2 * W;
  localparam int CW  = $clog2(NPP + 1);
  localparam int WB  = (XLEN >= WORD_BITS) ? WORD_BITS : XLEN;

  localparam logic [CW-1:0] CNT_END  = CW'(NPP);
  localparam logic [CW-1:0] CNT_STEP = CW'(PP_PER_CYCLE);

  state_e state_q;
  state_e state_d;

  logic [W-1:0]    x_q;
  logic [W:0]      y_q;
  logic [AW-1:0]   acc_q;
  logic [CW-1:0]   cnt_q;
  logic            high_q;
  logic            word_q;

  logic [XLEN-1:0] a_src;
  logic [XLEN-1:0] b_src;
  logic            a_sgn;
  logic            b_sgn;
  logic [W-1:0]    a_ext;
  logic [W-1:0]    b_ext;

  logic [W:0]      pp [PP_PER_CYCLE];
  logic [AW-1:0]   pp_sum;
  logic [AW-1:0]   acc_nxt;
  logic [XLEN-1:0] res_sel;

  logic            accept;
  logic            calc_last;

  assign accept    = (state_q == S_IDLE) && in_valid && !flush;
  assign calc_last = (state_q == S_CALC) && (cnt_q == CNT_END);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (in_valid)            state_d = S_CALC;
      S_CALC:  if (cnt_q == CNT_END)    state_d = S_DONE;
      S_DONE:  if (out_ready)           state_d = S_IDLE;
      default:                          state_d = S_IDLE;
    endcase
    if (flush) state_d = S_IDLE;
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      S_IDLE:  in_ready  = 1'b1;
      S_DONE:  out_valid = 1'b1;
      default: ;
    endcase
  end

  // Word mode sign-extends from bit 31 regardless of the signed flags.
  always_comb begin
    a_src = src1;
    b_src = src2;
    a_sgn = src1_signed & src1[XLEN-1];
    b_sgn = src2_signed & src2[XLEN-1];
    if (word) begin
      a_src = XLEN'($signed(src1[WB-1:0]));
      b_src = XLEN'($signed(src2[WB-1:0]));
      a_sgn = src1[WB-1];
      b_sgn = src2[WB-1];
    end
    a_ext = {{2{a_sgn}}, a_src};
    b_ext = {{2{b_sgn}}, b_src};
  end

  // y_q carries the implicit y[-1]=0 in bit 0 and is consumed from the bottom.
  for (genvar k = 0; k < PP_PER_CYCLE; k++) begin : g_pp
    booth_pp_gen #(.W(W)) u_pp (
      .sel   (y_q[2*k+2:2*k]),
      .mcand (x_q),
      .pp    (pp[k])
    );
  end

  always_comb begin
    pp_sum = '0;
    for (int k = 0; k < PP_PER_CYCLE; k++) begin
      pp_sum = pp_sum + (AW'($signed(pp[k])) << (2 * k));
    end
  end

  assign acc_nxt = acc_q + (pp_sum << {cnt_q, 1'b0});

  always_comb begin
    if (word_q)      res_sel = XLEN'($signed(acc_q[WB-1:0]));
    else if (high_q) res_sel = acc_q[2*XLEN-1:XLEN];
    else             res_sel = acc_q[XLEN-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q    <= '0;
      y_q    <= '0;
      acc_q  <= '0;
      cnt_q  <= '0;
      high_q <= 1'b0;
      word_q <= 1'b0;
      result <= '0;
    end else if (accept) begin
      x_q    <= a_ext;
      y_q    <= {b_ext, 1'b0};
      acc_q  <= '0;
      cnt_q  <= '0;
      high_q <= high & ~word;
      word_q <= word;
    end else if (state_q == S_CALC && !flush) begin
      if (calc_last) begin
        result <= res_sel;
      end else begin
        acc_q <= acc_nxt;
        cnt_q <= cnt_q + CNT_STEP;
        y_q   <= y_q >> (2 * PP_PER_CYCLE);
      end
    end
  end

endmodule

// File: tb/tb_booth_mul_iter.sv
// Directed bench for booth_mul_iter: three instances (1, 3 and 11 partial
// products per cycle) share stimulus; flush/reset/backpressure use the first.
module tb_booth_mul_iter;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic [63:0] src1;
  logic [63:0] src2;
  logic        src1_signed;
  logic        src2_signed;
  logic        high;
  logic        word;
  logic        out_ready;

  logic        ir  [3];
  logic        ov  [3];
  logic [63:0] res [3];

  logic [63:0] got_res [3];
  int          got_lat [3];
  int          ppc_of  [3] = '{1, 3, 11};
  int          exp_lat [3] = '{34, 12, 4};

  int n_chk  = 0;
  int n_pass = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  booth_mul_iter #(.XLEN(64), .PP_PER_CYCLE(1)) u_p1 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(ir[0]),
    .src1(src1), .src2(src2), .src1_signed(src1_signed), .src2_signed(src2_signed),
    .high(high), .word(word), .out_valid(ov[0]), .out_ready(out_ready), .result(res[0])
  );

  booth_mul_iter #(.XLEN(64), .PP_PER_CYCLE(3)) u_p3 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(ir[1]),
    .src1(src1), .src2(src2), .src1_signed(src1_signed), .src2_signed(src2_signed),
    .high(high), .word(word), .out_valid(ov[1]), .out_ready(out_ready), .result(res[1])
  );

  booth_mul_iter #(.XLEN(64), .PP_PER_CYCLE(11)) u_p11 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(ir[2]),
    .src1(src1), .src2(src2), .src1_signed(src1_signed), .src2_signed(src2_signed),
    .high(high), .word(word), .out_valid(ov[2]), .out_ready(out_ready), .result(res[2])
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%016h, expected 0x%016h", tag, got, exp);
  endtask

  task automatic wait_idle();
    int cyc;
    cyc = 0;
    while (!(ir[0] && ir[1] && ir[2]) && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    if (cyc >= 100) chk("idle_timeout", 64'd0, 64'd1);
  endtask

  // Issue one request to all instances and capture each result and latency.
  task automatic do_op(input logic [63:0] a, input logic [63:0] b,
                       input logic s1, input logic s2, input logic hi,
                       input logic wd, input logic rdy);
    int cyc;
    bit seen [3];
    wait_idle();
    src1 = a; src2 = b; src1_signed = s1; src2_signed = s2;
    high = hi; word = wd; out_ready = rdy; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      seen[k] = 1'b0;
      got_lat[k] = -1;
      got_res[k] = '1;
    end
    cyc = 0;
    while (!(seen[0] && seen[1] && seen[2]) && cyc <= 100) begin
      for (int k = 0; k < 3; k++) begin
        if (!seen[k] && ov[k]) begin
          seen[k] = 1'b1;
          got_res[k] = res[k];
          got_lat[k] = cyc;
        end
      end
      @(negedge clk);
      cyc++;
    end
    for (int k = 0; k < 3; k++)
      if (!seen[k]) chk($sformatf("valid_timeout_p%0d", ppc_of[k]), 64'd0, 64'd1);
  endtask

  task automatic check_all(input string tag, input logic [63:0] exp);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("%s_res_p%0d", tag, ppc_of[k]), got_res[k], exp);
      chk($sformatf("%s_lat_p%0d", tag, ppc_of[k]), 64'(got_lat[k]), 64'(exp_lat[k]));
    end
  endtask

  task automatic watch_valid(input int n, output bit seen);
    seen = 1'b0;
    repeat (n) begin
      if (ov[0]) seen = 1'b1;
      @(negedge clk);
    end
  endtask

  initial begin
    bit seen;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; src1 = '0; src2 = '0;
    src1_signed = 1'b0; src2_signed = 1'b0; high = 1'b0; word = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst_ready_p%0d", ppc_of[k]), 64'(ir[k]), 64'd1);
      chk($sformatf("rst_valid_p%0d", ppc_of[k]), 64'(ov[k]), 64'd0);
      chk($sformatf("rst_result_p%0d", ppc_of[k]), res[k], 64'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    do_op(64'd3, 64'd5, 1, 1, 0, 0, 1);
    check_all("signed_low", 64'd15);
    do_op('1, '1, 0, 0, 1, 0, 1);
    check_all("unsigned_high", 64'hFFFF_FFFF_FFFF_FFFE);
    do_op('1, '1, 1, 1, 1, 0, 1);
    check_all("signed_high", 64'h0);
    do_op('1, '1, 1, 1, 0, 0, 1);
    check_all("signed_low_m1", 64'h1);
    do_op('1, '1, 1, 0, 1, 0, 1);
    check_all("mulhsu", 64'hFFFF_FFFF_FFFF_FFFF);
    do_op(64'h0000_0000_7FFF_FFFF, 64'd2, 0, 0, 0, 1, 1);
    check_all("word", 64'hFFFF_FFFF_FFFF_FFFE);
    do_op(64'hDEAD_BEEF_7FFF_FFFF, 64'h1234_5678_0000_0002, 1, 0, 1, 1, 1);
    check_all("word_garbage", 64'hFFFF_FFFF_FFFF_FFFE);
    do_op(64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1, 1, 0, 0, 1);
    check_all("zero", 64'd0);

    // Backpressure: result and out_valid hold while out_ready is low.
    do_op(64'h1234, 64'h10, 1, 1, 0, 0, 0);
    check_all("bp", 64'h12340);
    for (int i = 0; i < 10; i++) begin
      chk("bp_valid_hold", 64'(ov[0]), 64'd1);
      chk("bp_result_hold", res[0], 64'h12340);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_valid", 64'(ov[0]), 64'd0);
    chk("bp_release_ready", 64'(ir[0]), 64'd1);

    // Flush at the 10th CALC cycle.
    wait_idle();
    src1 = 64'd100; src2 = 64'd100; src1_signed = 1; src2_signed = 1;
    high = 0; word = 0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    watch_valid(9, seen);
    chk("flush_early_valid", 64'(seen), 64'd0);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_ready_next", 64'(ir[0]), 64'd1);
    watch_valid(40, seen);
    chk("flush_no_valid", 64'(seen), 64'd0);
    do_op(64'd7, 64'd6, 1, 1, 0, 0, 1);
    check_all("post_flush", 64'd42);

    // Flush coincident with a request in IDLE drops it.
    wait_idle();
    src1 = 64'd9; src2 = 64'd9; in_valid = 1'b1; flush = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b0;
    chk("idle_flush_ready", 64'(ir[0]), 64'd1);
    watch_valid(40, seen);
    chk("idle_flush_dropped", 64'(seen), 64'd0);

    // Flush and out_ready together in DONE.
    do_op(64'd11, 64'd11, 0, 0, 0, 0, 0);
    check_all("done_flush", 64'd121);
    flush = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("done_flush_valid", 64'(ov[0]), 64'd0);
    chk("done_flush_ready", 64'(ir[0]), 64'd1);

    // Asynchronous reset during CALC.
    wait_idle();
    src1 = 64'd5; src2 = 64'd5; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_ready", 64'(ir[0]), 64'd1);
    chk("rst_mid_valid", 64'(ov[0]), 64'd0);
    chk("rst_mid_result", res[0], 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_op(64'hFFFF_FFFF_FFFF_FFF8, 64'd8, 1, 1, 0, 0, 1);
    check_all("post_reset", 64'hFFFF_FFFF_FFFF_FFC0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
